// File: rtl/ddr_score_pkg.sv
// Shared types and constants for the DDR scoring pipeline: grade encodings,
// default point weights and a helper for sizing per-lane hit counters.
package ddr_score_pkg;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'b00,
    GRADE_GOOD    = 2'b01,
    GRADE_PERFECT = 2'b10,
    GRADE_MISS_11 = 2'b11
  } grade_e;

  // One-hot judgement strobe produced by each lane for a single cycle.
  typedef struct packed {
    logic perfect;
    logic good;
    logic miss;
  } judge_t;

  localparam int DEF_PTS_PERFECT = 3;
  localparam int DEF_PTS_GOOD    = 1;

  // Width needed to count 0..lanes simultaneous events.
  function automatic int cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/score_lane_judge.sv
// Per-lane rising-edge detector and grade decoder: emits one one-hot
// {perfect,good,miss} strobe per 0->1 transition of the lane's action level.
module score_lane_judge
  import ddr_score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_action,
  input  logic [1:0] i_grade,
  output judge_t     o_judge
);

  logic   r_action_q;
  logic   w_edge;
  grade_e w_grade;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_action_q <= 1'b0;
    end else if (i_clear) begin
      r_action_q <= 1'b0;
    end else begin
      r_action_q <= i_action;
    end
  end

  // History updates even while paused, so resuming does not replay a held lane.
  assign w_edge  = i_action & ~r_action_q & i_enable;
  assign w_grade = grade_e'(i_grade);

  always_comb begin
    o_judge = '0;
    if (w_edge) begin
      case (w_grade)
        GRADE_PERFECT: o_judge.perfect = 1'b1;
        GRADE_GOOD:    o_judge.good    = 1'b1;
        default:       o_judge.miss    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/score_keeper_multi.sv
// Two-stage DDR scorer: stage 1 counts per-grade lane events, stage 2 applies
// grade-weighted points at the current multiplier and tracks combo/multiplier.
module score_keeper_multi
  import ddr_score_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int SCORE_W     = 16,
  parameter int MULT_W      = 7,
  parameter int MULT_MAX    = 4,
  parameter int COMBO_STEP  = 8,
  parameter int COMBO_W     = 10,
  parameter int PTS_PERFECT = DEF_PTS_PERFECT,
  parameter int PTS_GOOD    = DEF_PTS_GOOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [LANES-1:0]     note_action,
  input  logic [2*LANES-1:0]   note_grade,
  output logic [SCORE_W-1:0]   score,
  output logic [MULT_W-1:0]    multiplier,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo,
  output logic                 score_valid,
  output logic                 overflow
);

  localparam int CNT_W  = cnt_w(LANES);
  localparam int PTS_W  = SCORE_W + 8;
  localparam int STEP_W = $clog2(COMBO_STEP + LANES + 1);
  localparam int CSUM_W = COMBO_W + CNT_W;

  localparam logic [SCORE_W-1:0] SCORE_SAT = '1;
  localparam logic [COMBO_W-1:0] COMBO_SAT = '1;
  localparam logic [MULT_W-1:0]  MULT_ONE  = MULT_W'(1);
  localparam logic [MULT_W-1:0]  MULT_TOP  = MULT_W'(MULT_MAX);

  judge_t [LANES-1:0] w_judge;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    score_lane_judge u_judge (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (clear),
      .i_enable (enable),
      .i_action (note_action[g]),
      .i_grade  (note_grade[2*g+1:2*g]),
      .o_judge  (w_judge[g])
    );
  end

  // ---------------- stage 1: per-grade event counts ----------------
  logic [CNT_W-1:0] w_cnt_perfect, w_cnt_good, w_cnt_miss;
  logic             w_any_evt;

  // NOTE: every always_comb output gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    w_cnt_perfect = '0;
    w_cnt_good    = '0;
    w_cnt_miss    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_cnt_perfect = w_cnt_perfect + CNT_W'(w_judge[i].perfect);
      w_cnt_good    = w_cnt_good    + CNT_W'(w_judge[i].good);
      w_cnt_miss    = w_cnt_miss    + CNT_W'(w_judge[i].miss);
    end
    w_any_evt = |w_judge;
  end

  logic [CNT_W-1:0] r_n_perfect, r_n_good, r_n_miss;
  logic             r_any_evt;

  // NOTE: only control/datapath flops are reset; there is no storage array
  // here, so every register returns to a known value on rst and on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_perfect <= '0;
      r_n_good    <= '0;
      r_n_miss    <= '0;
      r_any_evt   <= 1'b0;
    end else if (clear) begin
      r_n_perfect <= '0;
      r_n_good    <= '0;
      r_n_miss    <= '0;
      r_any_evt   <= 1'b0;
    end else begin
      r_n_perfect <= w_cnt_perfect;
      r_n_good    <= w_cnt_good;
      r_n_miss    <= w_cnt_miss;
      r_any_evt   <= w_any_evt;
    end
  end

  // ---------------- stage 2: score, combo, multiplier ----------------
  logic [SCORE_W-1:0] r_score;
  logic [MULT_W-1:0]  r_mult;
  logic [COMBO_W-1:0] r_combo, r_max_combo;
  logic [STEP_W-1:0]  r_step;
  logic               r_valid, r_ovf;

  logic [SCORE_W-1:0] w_score_n;
  logic [MULT_W-1:0]  w_mult_n;
  logic [COMBO_W-1:0] w_combo_n, w_max_combo_n;
  logic [STEP_W-1:0]  w_step_n, w_step_sum;
  logic               w_valid_n, w_ovf_n;
  logic [CNT_W-1:0]   w_hits;
  logic [PTS_W-1:0]   w_base, w_pts;
  logic [PTS_W:0]     w_sum;
  logic [CSUM_W-1:0]  w_combo_sum;

  always_comb begin
    w_hits      = r_n_perfect + r_n_good;
    w_base      = PTS_W'(r_n_perfect) * PTS_W'(PTS_PERFECT)
                + PTS_W'(r_n_good)    * PTS_W'(PTS_GOOD);
    w_pts       = w_base * PTS_W'(r_mult);
    w_sum       = (PTS_W+1)'(r_score) + (PTS_W+1)'(w_pts);
    w_combo_sum = CSUM_W'(r_combo) + CSUM_W'(w_hits);
    w_step_sum  = r_step + STEP_W'(w_hits);

    w_score_n     = r_score;
    w_mult_n      = r_mult;
    w_combo_n     = r_combo;
    w_max_combo_n = r_max_combo;
    w_step_n      = r_step;
    w_ovf_n       = r_ovf;
    w_valid_n     = 1'b0;

    if (r_any_evt) begin
      w_valid_n = 1'b1;
      if (w_sum > (PTS_W+1)'(SCORE_SAT)) begin
        w_score_n = SCORE_SAT;
        w_ovf_n   = 1'b1;
      end else begin
        w_score_n = w_sum[SCORE_W-1:0];
      end

      // A miss breaks the streak; hits in the same cycle already scored above.
      if (r_n_miss != '0) begin
        w_combo_n = '0;
        w_step_n  = '0;
        w_mult_n  = MULT_ONE;
      end else begin
        if (w_combo_sum > CSUM_W'(COMBO_SAT)) begin
          w_combo_n = COMBO_SAT;
        end else begin
          w_combo_n = w_combo_sum[COMBO_W-1:0];
        end
        if (w_step_sum >= STEP_W'(COMBO_STEP)) begin
          w_step_n = w_step_sum - STEP_W'(COMBO_STEP);
          if (r_mult < MULT_TOP) begin
            w_mult_n = r_mult + MULT_ONE;
          end
        end else begin
          w_step_n = w_step_sum;
        end
      end

      if (w_combo_n > r_max_combo) begin
        w_max_combo_n = w_combo_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score     <= '0;
      r_mult      <= MULT_ONE;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_step      <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (clear) begin
      r_score     <= '0;
      r_mult      <= MULT_ONE;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_step      <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_score     <= w_score_n;
      r_mult      <= w_mult_n;
      r_combo     <= w_combo_n;
      r_max_combo <= w_max_combo_n;
      r_step      <= w_step_n;
      r_valid     <= w_valid_n;
      r_ovf       <= w_ovf_n;
    end
  end

  assign score       = r_score;
  assign multiplier  = r_mult;
  assign combo       = r_combo;
  assign max_combo   = r_max_combo;
  assign score_valid = r_valid;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_score_keeper_multi.sv
// Directed bench for score_keeper_multi: a default instance and an 8-bit-score
// instance share stimulus; expected values are hand-computed.
module tb_score_keeper_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        enable;
  logic [3:0]  note_action;
  logic [7:0]  note_grade;

  logic [15:0] score;
  logic [6:0]  multiplier;
  logic [9:0]  combo, max_combo;
  logic        score_valid, overflow;

  logic [7:0]  score8;
  logic [6:0]  multiplier8;
  logic [9:0]  combo8, max_combo8;
  logic        score_valid8, overflow8;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses;

  always #5 clk = ~clk;

  score_keeper_multi dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .enable      (enable),
    .note_action (note_action),
    .note_grade  (note_grade),
    .score       (score),
    .multiplier  (multiplier),
    .combo       (combo),
    .max_combo   (max_combo),
    .score_valid (score_valid),
    .overflow    (overflow)
  );

  score_keeper_multi #(.SCORE_W(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .enable      (enable),
    .note_action (note_action),
    .note_grade  (note_grade),
    .score       (score8),
    .multiplier  (multiplier8),
    .combo       (combo8),
    .max_combo   (max_combo8),
    .score_valid (score_valid8),
    .overflow    (overflow8)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One judgement: raise lanes for a cycle, lower them, return just after
  // the cycle in which the result becomes visible.
  task automatic hit(input logic [3:0] mask, input logic [7:0] grades);
    note_action = mask;
    note_grade  = grades;
    @(negedge clk);
    note_action = '0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic count_pulses(input int cycles);
    n_pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_pulses += int'(score_valid);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    note_action = '0; note_grade = '0;

    // 1: asynchronous reset values before any clock edge
    #3;
    check("rst_score", score, 0);
    check("rst_mult", multiplier, 1);
    check("rst_combo", combo, 0);
    check("rst_max", max_combo, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid", score_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: single perfect on lane 0, latency and hold-high behaviour
    note_action = 4'b0001;
    note_grade  = 8'b00_00_00_10;
    @(negedge clk);
    check("t2_valid_t1", score_valid, 0);
    @(negedge clk);
    check("t2_valid_t2", score_valid, 1);
    check("t2_score", score, 3);
    check("t2_combo", combo, 1);
    count_pulses(10);
    check("t2_hold_pulses", n_pulses, 0);
    check("t2_hold_score", score, 3);
    note_action = '0;
    @(negedge clk);

    // 3: nine sequential perfects on lane 1 from a fresh start
    do_clear();
    check("clr_score", score, 0);
    check("clr_combo", combo, 0);
    for (int k = 1; k <= 9; k++) begin
      hit(4'b0010, 8'b00_00_10_00);
      if (k == 8) begin
        check("t3_mult_8", multiplier, 2);
        check("t3_score_8", score, 24);
      end
    end
    check("t3_score_9", score, 30);
    check("t3_combo_9", combo, 9);
    check("t3_max_9", max_combo, 9);

    // 4: mixed same-cycle hits with one miss at multiplier 2
    hit(4'b1111, 8'b10_00_01_10);
    check("t4_valid", score_valid, 1);
    check("t4_score", score, 44);
    check("t4_combo", combo, 0);
    check("t4_mult", multiplier, 1);
    check("t4_max", max_combo, 9);
    @(negedge clk);
    check("t4_valid_gone", score_valid, 0);

    // 6a: paused edge is discarded and not replayed on resume
    enable = 1'b0;
    note_action = 4'b0001;
    note_grade  = 8'b00_00_00_10;
    count_pulses(3);
    check("pause_pulses", n_pulses, 0);
    enable = 1'b1;
    count_pulses(3);
    check("resume_pulses", n_pulses, 0);
    check("pause_score", score, 44);
    note_action = '0;
    @(negedge clk);

    // pausing after stage 1 still lets the in-flight update land
    note_action = 4'b0001;
    @(negedge clk);
    enable = 1'b0;
    note_action = '0;
    @(negedge clk);
    check("inflight_valid", score_valid, 1);
    check("inflight_score", score, 47);
    enable = 1'b1;
    @(negedge clk);

    // 5: saturation on the 8-bit instance, all four lanes perfect each event
    do_clear();
    for (int k = 1; k <= 9; k++) begin
      hit(4'b1111, 8'b10_10_10_10);
      if (k == 8) begin
        check("t5_small_240", score8, 240);
        check("t5_small_ovf_8", overflow8, 0);
      end
    end
    check("t5_small_sat", score8, 255);
    check("t5_small_ovf", overflow8, 1);
    check("t5_big_score", score, 288);
    check("t5_big_ovf", overflow, 0);
    check("t5_big_mult", multiplier, 4);
    check("t5_big_combo", combo, 36);
    hit(4'b1111, 8'b10_10_10_10);
    check("t5_small_hold", score8, 255);
    do_clear();
    check("t5_clr_score", score8, 0);
    check("t5_clr_ovf", overflow8, 0);
    check("t5_clr_mult", multiplier8, 1);
    check("t5_clr_max", max_combo8, 0);

    // 6b: reset one cycle after an edge drops the in-flight judgement
    hit(4'b0001, 8'b00_00_00_10);
    check("t6_pre_score", score, 3);
    note_action = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    note_action = '0;
    #1;
    check("t6_rst_score", score, 0);
    check("t6_rst_combo", combo, 0);
    check("t6_rst_max", max_combo, 0);
    @(negedge clk);
    rst = 1'b0;
    count_pulses(4);
    check("t6_post_pulses", n_pulses, 0);
    check("t6_post_score", score, 0);
    check("t6_post_mult", multiplier, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
